// File: rtl/tcdm_error_slave_pkg.sv
// Shared interconnect types for the TCDM error slave: capture-state encoding,
// default error read data and the TCDM bus widths.
package pkg_soc_interconnect;

    localparam int unsigned TCDM_ADDR_W = 32;
    localparam int unsigned TCDM_DATA_W = 32;
    localparam int unsigned TCDM_BE_W   = 4;

    typedef enum logic [1:0] {
        EMPTY    = 2'd0,
        CAPTURED = 2'd1,
        OVERRUN  = 2'd2
    } err_state_e;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hBADACCE5;

endpackage

// File: rtl/tcdm_error_slave_resp_pipe.sv
// Response timing for the error slave: a RESP_LAT-deep shift register of
// valid bits, so each accepted request emerges exactly RESP_LAT cycles later.
module tcdm_err_resp_pipe #(
    parameter int unsigned RESP_LAT = 1
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic in_i,
    output logic out_o
);

    logic [RESP_LAT-1:0] valid_sr;

    if (RESP_LAT == 1) begin : g_single
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_sr <= '0;
            end else begin
                valid_sr <= in_i;
            end
        end
    end else begin : g_shift
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                valid_sr <= '0;
            end else begin
                valid_sr <= {valid_sr[RESP_LAT-2:0], in_i};
            end
        end
    end

    assign out_o = valid_sr[RESP_LAT-1];

endmodule

// File: rtl/tcdm_error_slave.sv
// Default error port of the TCDM crossbar: grants everything, answers with an
// error response, and records the first faulting access plus an error count.
// Optional interrupt output is built when TCDM_ERR_SLAVE_IRQ_EN is defined.
module tcdm_error_slave
    import pkg_soc_interconnect::*;
#(
    parameter int unsigned RESP_LAT  = 1,
    parameter int unsigned CNT_WIDTH = 8,
    parameter logic [31:0] ERR_RDATA = ERR_RDATA_DEFAULT
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_i,
    input  logic [TCDM_ADDR_W-1:0] add_i,
    input  logic                   wen_i,
    input  logic [TCDM_DATA_W-1:0] wdata_i,
    input  logic [TCDM_BE_W-1:0]   be_i,
    output logic                   gnt_o,
    output logic                   r_valid_o,
    output logic                   r_opc_o,
    output logic [TCDM_DATA_W-1:0] r_rdata_o,
    input  logic                   clr_i,
    output logic                   err_valid_o,
    output logic                   err_overrun_o,
    output logic [TCDM_ADDR_W-1:0] err_addr_o,
    output logic                   err_wen_o,
    output logic [TCDM_BE_W-1:0]   err_be_o,
    output logic [CNT_WIDTH-1:0]   err_cnt_o,
    output logic                   irq_o
);

    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    err_state_e state;
    logic       hs;
    logic       resp_valid;
    logic       unused_wdata;

    // Write data is never stored; an error access has no side effects.
    assign unused_wdata = ^wdata_i;

    assign gnt_o = req_i & ~rst_i;
    assign hs    = req_i & gnt_o;

    tcdm_err_resp_pipe #(
        .RESP_LAT (RESP_LAT)
    ) u_resp_pipe (
        .clk_i (clk_i),
        .rst_i (rst_i),
        .in_i  (hs),
        .out_o (resp_valid)
    );

    assign r_valid_o = resp_valid;
    assign r_opc_o   = resp_valid;
    assign r_rdata_o = resp_valid ? ERR_RDATA : '0;

    // Capture FSM and saturating counter; a clear in a handshake cycle
    // discards the old record and captures the new access.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state         <= EMPTY;
            err_valid_o   <= 1'b0;
            err_overrun_o <= 1'b0;
            err_addr_o    <= '0;
            err_wen_o     <= 1'b0;
            err_be_o      <= '0;
            err_cnt_o     <= '0;
        end else if (clr_i) begin
            if (hs) begin
                state         <= CAPTURED;
                err_valid_o   <= 1'b1;
                err_overrun_o <= 1'b0;
                err_addr_o    <= add_i;
                err_wen_o     <= wen_i;
                err_be_o      <= be_i;
                err_cnt_o     <= CNT_WIDTH'(1);
            end else begin
                state         <= EMPTY;
                err_valid_o   <= 1'b0;
                err_overrun_o <= 1'b0;
                err_addr_o    <= '0;
                err_wen_o     <= 1'b0;
                err_be_o      <= '0;
                err_cnt_o     <= '0;
            end
        end else if (hs) begin
            case (state)
                EMPTY: begin
                    state       <= CAPTURED;
                    err_valid_o <= 1'b1;
                    err_addr_o  <= add_i;
                    err_wen_o   <= wen_i;
                    err_be_o    <= be_i;
                end
                CAPTURED, OVERRUN: begin
                    state         <= OVERRUN;
                    err_overrun_o <= 1'b1;
                end
                default: begin
                    state <= EMPTY;
                end
            endcase
            if (err_cnt_o != CNT_MAX) begin
                err_cnt_o <= err_cnt_o + CNT_WIDTH'(1);
            end
        end
    end

`ifdef TCDM_ERR_SLAVE_IRQ_EN
    logic irq_q;

    // Follows the capture state: set when it leaves EMPTY, dropped by a clear.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            irq_q <= 1'b0;
        end else if (hs) begin
            irq_q <= 1'b1;
        end else if (clr_i) begin
            irq_q <= 1'b0;
        end
    end

    assign irq_o = irq_q;
`else
    assign irq_o = 1'b0;
`endif

endmodule

// File: tb/tb_tcdm_error_slave.sv
// Self-checking bench: two instances (RESP_LAT=1/CNT_WIDTH=8 and
// RESP_LAT=3/CNT_WIDTH=4) share stimulus; responses are checked by scoreboard.
module tb_tcdm_error_slave;

`ifdef TCDM_ERR_SLAVE_IRQ_EN
    localparam logic IRQ_EXP = 1'b1;
`else
    localparam logic IRQ_EXP = 1'b0;
`endif
    localparam logic [31:0] RDATA_EXP = 32'hBADACCE5;

    logic        clk = 1'b0;
    logic        rst;
    logic        req;
    logic [31:0] add;
    logic        wen;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        clr;

    logic        gnt_a, rv_a, opc_a, ev_a, eo_a, ew_a, irq_a;
    logic [31:0] rd_a, ea_a;
    logic [3:0]  eb_a;
    logic [7:0]  ec_a;
    logic        gnt_b, rv_b, opc_b, ev_b, eo_b, ew_b, irq_b;
    logic [31:0] rd_b, ea_b;
    logic [3:0]  eb_b;
    logic [3:0]  ec_b;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int vcnt_b = 0;
    int qa[$];
    int qb[$];

    tcdm_error_slave #(.RESP_LAT(1), .CNT_WIDTH(8)) dut_a (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_a), .r_valid_o(rv_a),
        .r_opc_o(opc_a), .r_rdata_o(rd_a), .clr_i(clr), .err_valid_o(ev_a),
        .err_overrun_o(eo_a), .err_addr_o(ea_a), .err_wen_o(ew_a),
        .err_be_o(eb_a), .err_cnt_o(ec_a), .irq_o(irq_a)
    );

    tcdm_error_slave #(.RESP_LAT(3), .CNT_WIDTH(4)) dut_b (
        .clk_i(clk), .rst_i(rst), .req_i(req), .add_i(add), .wen_i(wen),
        .wdata_i(wdata), .be_i(be), .gnt_o(gnt_b), .r_valid_o(rv_b),
        .r_opc_o(opc_b), .r_rdata_o(rd_b), .clr_i(clr), .err_valid_o(ev_b),
        .err_overrun_o(eo_b), .err_addr_o(ea_b), .err_wen_o(ew_b),
        .err_be_o(eb_b), .err_cnt_o(ec_b), .irq_o(irq_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: expected response cycles are queued when a request is seen.
    always @(negedge clk) begin
        checks++;
        if (gnt_a !== (req & ~rst) || gnt_b !== (req & ~rst)) begin
            errors++;
            $display("FAIL gnt cyc=%0d got a=%b b=%b expected %b", cyc, gnt_a, gnt_b, req & ~rst);
        end
        if (rst) begin
            qa.delete();
            qb.delete();
            checks++;
            if (rv_a !== 1'b0 || rv_b !== 1'b0) begin
                errors++;
                $display("FAIL resp_in_reset cyc=%0d got a=%b b=%b expected 0", cyc, rv_a, rv_b);
            end
        end else begin
            checks++;
            if (rv_a) begin
                if (qa.size() == 0 || qa[0] != cyc) begin
                    errors++;
                    $display("FAIL resp_a_timing cyc=%0d got r_valid=1 expected none here", cyc);
                end else begin
                    void'(qa.pop_front());
                end
                if (opc_a !== 1'b1 || rd_a !== RDATA_EXP) begin
                    errors++;
                    $display("FAIL resp_a_data cyc=%0d got opc=%b rdata=%h expected 1/%h", cyc, opc_a, rd_a, RDATA_EXP);
                end
            end else begin
                if (qa.size() != 0 && qa[0] == cyc) begin
                    errors++;
                    $display("FAIL resp_a_missing cyc=%0d got r_valid=0 expected 1", cyc);
                    void'(qa.pop_front());
                end
                if (opc_a !== 1'b0 || rd_a !== 32'h0) begin
                    errors++;
                    $display("FAIL resp_a_idle cyc=%0d got opc=%b rdata=%h expected 0/0", cyc, opc_a, rd_a);
                end
            end
            checks++;
            if (rv_b) begin
                vcnt_b++;
                if (qb.size() == 0 || qb[0] != cyc) begin
                    errors++;
                    $display("FAIL resp_b_timing cyc=%0d got r_valid=1 expected none here", cyc);
                end else begin
                    void'(qb.pop_front());
                end
                if (opc_b !== 1'b1 || rd_b !== RDATA_EXP) begin
                    errors++;
                    $display("FAIL resp_b_data cyc=%0d got opc=%b rdata=%h expected 1/%h", cyc, opc_b, rd_b, RDATA_EXP);
                end
            end else begin
                if (qb.size() != 0 && qb[0] == cyc) begin
                    errors++;
                    $display("FAIL resp_b_missing cyc=%0d got r_valid=0 expected 1", cyc);
                    void'(qb.pop_front());
                end
                if (opc_b !== 1'b0 || rd_b !== 32'h0) begin
                    errors++;
                    $display("FAIL resp_b_idle cyc=%0d got opc=%b rdata=%h expected 0/0", cyc, opc_b, rd_b);
                end
            end
            if (req) begin
                qa.push_back(cyc + 1);
                qb.push_back(cyc + 3);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 12 && (qa.size() != 0 || qb.size() != 0); i++) @(negedge clk);
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL drain_%s got pending a=%0d b=%0d expected 0/0", name, qa.size(), qb.size());
        end
    endtask

    task automatic pulse_clear();
        step(); req = 1'b0; clr = 1'b1;
        step(); clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; req = 1'b1; add = 32'h1000_0000; wen = 1'b1; be = 4'hF; clr = 1'b0; wdata = '0;
        step(); step();
        @(negedge clk);
        checks++;
        if ({ev_a, eo_a, ea_a, ew_a, eb_a, ec_a, irq_a, rv_a, opc_a, rd_a, gnt_a} !== '0 ||
            {ev_b, eo_b, ea_b, ew_b, eb_b, ec_b, irq_b, rv_b, opc_b, rd_b, gnt_b} !== '0) begin
            errors++;
            $display("FAIL reset_state got a_valid=%b a_cnt=%0d a_gnt=%b b_valid=%b b_cnt=%0d expected all 0",
                     ev_a, ec_a, gnt_a, ev_b, ec_b);
        end
        step(); rst = 1'b0; req = 1'b0;
    endtask

    task automatic test_single_read();
        step(); req = 1'b1; add = 32'h1A20_0000; wen = 1'b1; be = 4'hF;
        @(negedge clk);
        checks++;
        if (gnt_a !== 1'b1) begin
            errors++;
            $display("FAIL single_gnt got %b expected 1", gnt_a);
        end
        step(); req = 1'b0;
        @(negedge clk);
        checks++;
        if (rv_a !== 1'b1 || opc_a !== 1'b1 || rd_a !== 32'hBADACCE5) begin
            errors++;
            $display("FAIL single_resp got valid=%b opc=%b rdata=%h expected 1/1/badacce5", rv_a, opc_a, rd_a);
        end
        drain("single");
    endtask

    task automatic test_capture();
        pulse_clear();
        @(negedge clk);
        checks++;
        if ({ev_a, eo_a, ea_a, ew_a, eb_a, ec_a, irq_a} !== '0) begin
            errors++;
            $display("FAIL clear_plain got valid=%b ovr=%b cnt=%0d irq=%b expected 0", ev_a, eo_a, ec_a, irq_a);
        end
        step(); req = 1'b1; add = 32'h1A20_0000; wen = 1'b1; be = 4'hF;
        step(); add = 32'h1C00_0010; wen = 1'b0; be = 4'b0011;
        @(negedge clk);
        checks++;
        if (irq_a !== IRQ_EXP || ev_a !== 1'b1) begin
            errors++;
            $display("FAIL irq_first got irq=%b valid=%b expected %b/1", irq_a, ev_a, IRQ_EXP);
        end
        step(); req = 1'b0;
        @(negedge clk);
        checks++;
        if (ea_a !== 32'h1A20_0000 || ew_a !== 1'b1 || eb_a !== 4'hF || eo_a !== 1'b1 ||
            ec_a !== 8'd2 || ev_a !== 1'b1) begin
            errors++;
            $display("FAIL capture_a got addr=%h wen=%b be=%h ovr=%b cnt=%0d expected 1a200000/1/f/1/2",
                     ea_a, ew_a, eb_a, eo_a, ec_a);
        end
        checks++;
        if (ea_b !== 32'h1A20_0000 || eo_b !== 1'b1 || ec_b !== 4'd2) begin
            errors++;
            $display("FAIL capture_b got addr=%h ovr=%b cnt=%0d expected 1a200000/1/2", ea_b, eo_b, ec_b);
        end
        drain("capture");
    endtask

    task automatic test_clear();
        pulse_clear();
        @(negedge clk);
        checks++;
        if ({ev_a, eo_a, ea_a, ew_a, eb_a, ec_a, irq_a} !== '0 ||
            {ev_b, eo_b, ea_b, ew_b, eb_b, ec_b, irq_b} !== '0) begin
            errors++;
            $display("FAIL clear_no_hs got a_valid=%b a_cnt=%0d a_irq=%b b_cnt=%0d expected 0", ev_a, ec_a, irq_a, ec_b);
        end
        step(); req = 1'b1; add = 32'h3000_0000; wen = 1'b0; be = 4'h1;
        step(); clr = 1'b1; add = 32'h2000_0000; wen = 1'b1; be = 4'h5;
        step(); clr = 1'b0; req = 1'b0;
        @(negedge clk);
        checks++;
        if (ev_a !== 1'b1 || ea_a !== 32'h2000_0000 || ec_a !== 8'd1 || eo_a !== 1'b0 ||
            ew_a !== 1'b1 || eb_a !== 4'h5 || irq_a !== IRQ_EXP) begin
            errors++;
            $display("FAIL clear_with_hs got valid=%b addr=%h cnt=%0d ovr=%b wen=%b be=%h irq=%b expected 1/20000000/1/0/1/5/%b",
                     ev_a, ea_a, ec_a, eo_a, ew_a, eb_a, irq_a, IRQ_EXP);
        end
        checks++;
        if (ec_b !== 4'd1 || eo_b !== 1'b0) begin
            errors++;
            $display("FAIL clear_with_hs_b got cnt=%0d ovr=%b expected 1/0", ec_b, eo_b);
        end
        pulse_clear();
        @(negedge clk);
        checks++;
        if (irq_a !== 1'b0 || irq_b !== 1'b0 || ev_a !== 1'b0) begin
            errors++;
            $display("FAIL irq_clear got a=%b b=%b valid=%b expected 0/0/0", irq_a, irq_b, ev_a);
        end
        drain("clear");
    endtask

    task automatic test_back_to_back();
        int v0;
        v0 = vcnt_b;
        for (int i = 0; i < 10; i++) begin
            step(); req = 1'b1; add = 32'h4000_0000 + 32'(i * 4); wen = i[0]; be = 4'hF;
        end
        step(); req = 1'b0;
        drain("stream");
        checks++;
        if (vcnt_b - v0 != 10) begin
            errors++;
            $display("FAIL stream_count got %0d expected 10", vcnt_b - v0);
        end
        checks++;
        if (ec_a !== 8'd10 || ec_b !== 4'd10) begin
            errors++;
            $display("FAIL stream_cnt got a=%0d b=%0d expected 10/10", ec_a, ec_b);
        end
    endtask

    task automatic test_saturation();
        pulse_clear();
        for (int i = 0; i < 20; i++) begin
            step(); req = 1'b1; add = 32'h5000_0000 + 32'(i); wen = 1'b1; be = 4'h1;
        end
        step(); req = 1'b0;
        @(negedge clk);
        checks++;
        if (ec_a !== 8'd20 || ec_b !== 4'd15) begin
            errors++;
            $display("FAIL saturation got a=%0d b=%0d expected 20/15", ec_a, ec_b);
        end
        drain("saturation");
    endtask

    task automatic test_reset_mid_traffic();
        step(); req = 1'b1; add = 32'h6000_0000;
        step(); add = 32'h6000_0004;
        step(); req = 1'b0; rst = 1'b1;
        step(); rst = 1'b0;
        for (int i = 0; i < 6; i++) @(negedge clk);
        checks++;
        if ({ev_a, eo_a, ea_a, ew_a, eb_a, ec_a, irq_a} !== '0 ||
            {ev_b, eo_b, ea_b, ew_b, eb_b, ec_b, irq_b} !== '0) begin
            errors++;
            $display("FAIL reset_mid got a_valid=%b a_cnt=%0d b_valid=%b b_cnt=%0d irq=%b expected 0",
                     ev_a, ec_a, ev_b, ec_b, irq_b);
        end
        drain("reset_mid");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_capture();
        test_clear();
        test_back_to_back();
        test_saturation();
        test_reset_mid_traffic();
        step();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
